// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one registered full-adder cell processes one
// operand bit per clock, LSB first, and reports sum, carry-out and overflow.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    count;
   logic             bit_sum;
   logic             bit_carry;
   logic             last_bit;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   // Full-adder cell on the current LSBs and last-bit detection
   always_comb begin
      bit_sum   = fa_sum(shift_a[0], shift_b[0], carry);
      bit_carry = fa_carry(shift_a[0], shift_b[0], carry);
      last_bit  = (count == CW'(WIDTH - 1));
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_next = DONE;
            end else begin
               state_next = RUN;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register with busy/done registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
      end
   end

   // Operand capture, serial shifting and result registration
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_a <= {WIDTH{1'b0}};
         shift_b <= {WIDTH{1'b0}};
         acc     <= {WIDTH{1'b0}};
         carry   <= 1'b0;
         count   <= {CW{1'b0}};
         sum     <= {WIDTH{1'b0}};
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction runs as a + ~b + !cin
                  shift_a <= a;
                  shift_b <= sub ? ~b : b;
                  carry   <= sub ? ~cin : cin;
                  count   <= {CW{1'b0}};
               end
            end
            RUN: begin
               shift_a <= {1'b0, shift_a[WIDTH-1:1]};
               shift_b <= {1'b0, shift_b[WIDTH-1:1]};
               acc     <= {bit_sum, acc[WIDTH-1:1]};
               carry   <= bit_carry;
               count   <= count + CW'(1);
               if (last_bit) begin
                  sum  <= {bit_sum, acc[WIDTH-1:1]};
                  cout <= bit_carry;
                  ovf  <= carry ^ bit_carry;
               end
            end
            DONE: begin
               count <= {CW{1'b0}};
            end
            default: begin
               count <= {CW{1'b0}};
            end
         endcase
      end
   end

endmodule
